// File: rtl/cacheline_adapter_if.sv
// Line-side and burst-side bus bundles for the cache-line adapter.
// The cache is the line-bus master; the adapter is the burst-bus master toward memory.

interface line_bus_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
);
    logic [ADDR_WIDTH-1:0] line_address_i;
    logic                  line_read_i;
    logic                  line_write_i;
    logic [LINE_WIDTH-1:0] line_wdata_i;
    logic [LINE_WIDTH-1:0] line_rdata_o;
    logic                  line_resp_o;

    modport master (
        output line_address_i, line_read_i, line_write_i, line_wdata_i,
        input  line_rdata_o, line_resp_o
    );

    modport slave (
        input  line_address_i, line_read_i, line_write_i, line_wdata_i,
        output line_rdata_o, line_resp_o
    );
endinterface

interface burst_bus_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BURST_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]  mem_address_o;
    logic                   mem_read_o;
    logic                   mem_write_o;
    logic [BURST_WIDTH-1:0] mem_wdata_o;
    logic [BURST_WIDTH-1:0] mem_rdata_i;
    logic                   mem_resp_i;

    modport master (
        output mem_address_o, mem_read_o, mem_write_o, mem_wdata_o,
        input  mem_rdata_i, mem_resp_i
    );

    modport slave (
        input  mem_address_o, mem_read_o, mem_write_o, mem_wdata_o,
        output mem_rdata_i, mem_resp_i
    );
endinterface

// File: rtl/cacheline_adapter.sv
// Splits one cache-line read/write into a BEATS-long burst of BURST_WIDTH beats,
// then returns a single-cycle completion to the cache.

module cacheline_adapter #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic         clk,
    input  logic         rst,
    line_bus_if.slave    line,
    burst_bus_if.master  mem
);
    localparam int unsigned BEATS    = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned BEAT_W   = $clog2(BEATS);
    localparam int unsigned OFFSET_W = $clog2(LINE_WIDTH / 8);

    typedef logic [BEATS-1:0][BURST_WIDTH-1:0] line_t;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d, beat_inc;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    line_t                  wline_q, wline_d;
    line_t                  rline_q, rline_d;
    logic [BURST_WIDTH-1:0] wdata_q, wdata_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic                   resp_q, resp_d;
    logic                   last_beat;

    // Byte offset within a line is dropped by alignment.
    logic unused_offset;
    assign unused_offset = &{1'b0, line.line_address_i[OFFSET_W-1:0]};

    assign beat_inc  = beat_q + BEAT_W'(1);
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        wline_d     = wline_q;
        rline_d     = rline_q;
        wdata_d     = wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        resp_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (line.line_read_i) begin
                    addr_d     = {line.line_address_i[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
                    state_d    = READ;
                    mem_read_d = 1'b1;
                end else if (line.line_write_i) begin
                    addr_d      = {line.line_address_i[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
                    wline_d     = line.line_wdata_i;
                    wdata_d     = line.line_wdata_i[BURST_WIDTH-1:0];
                    state_d     = WRITE;
                    mem_write_d = 1'b1;
                end
            end
            READ: begin
                mem_read_d = 1'b1;
                if (mem.mem_resp_i) begin
                    rline_d[beat_q] = mem.mem_rdata_i;
                    beat_d          = beat_inc;
                    if (last_beat) begin
                        state_d    = DONE;
                        mem_read_d = 1'b0;
                        resp_d     = 1'b1;
                    end
                end
            end
            WRITE: begin
                mem_write_d = 1'b1;
                if (mem.mem_resp_i) begin
                    beat_d = beat_inc;
                    if (last_beat) begin
                        state_d     = DONE;
                        mem_write_d = 1'b0;
                        resp_d      = 1'b1;
                    end else begin
                        wdata_d = wline_q[beat_inc];
                    end
                end
            end
            DONE: begin
                beat_d  = '0;
                state_d = IDLE;
            end
            default: begin
                beat_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            addr_q      <= '0;
            wline_q     <= '0;
            rline_q     <= '0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            resp_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            wline_q     <= wline_d;
            rline_q     <= rline_d;
            wdata_q     <= wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            resp_q      <= resp_d;
        end
    end

    assign line.line_rdata_o = rline_q;
    assign line.line_resp_o  = resp_q;
    assign mem.mem_address_o = addr_q;
    assign mem.mem_read_o    = mem_read_q;
    assign mem.mem_write_o   = mem_write_q;
    assign mem.mem_wdata_o   = wdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized bench for cacheline_adapter: the bench plays cache and burst memory,
// predicting every beat and completion from a transaction-level model.

module tb_cacheline_adapter;
    localparam int unsigned LW = 256;
    localparam int unsigned BW = 64;
    localparam int unsigned AW = 32;
    localparam int unsigned NB = LW / BW;

    logic clk = 1'b0;
    logic rst;

    line_bus_if  #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW))  line_bus ();
    burst_bus_if #(.ADDR_WIDTH(AW), .BURST_WIDTH(BW)) mem_bus ();

    cacheline_adapter #(
        .LINE_WIDTH (LW),
        .BURST_WIDTH(BW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .line(line_bus),
        .mem (mem_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Line contents and address the cache should currently observe.
    logic [LW-1:0] model_rdata;
    logic [AW-1:0] model_addr;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_resp"},  LW'(line_bus.line_resp_o), LW'(0));
        check({tag, "_rd"},    LW'(mem_bus.mem_read_o),   LW'(0));
        check({tag, "_wr"},    LW'(mem_bus.mem_write_o),  LW'(0));
        check({tag, "_addr"},  LW'(mem_bus.mem_address_o), LW'(model_addr));
        check({tag, "_rdata"}, line_bus.line_rdata_o,     model_rdata);
    endtask

    // mode 0: back-to-back beats 0x11..,0x22..; mode 1: resp toggles 1,0,1..; else random gaps/data.
    task automatic do_txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [LW-1:0] wl, input int mode);
        logic [BW-1:0] beat_q[$];
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_line;
        logic [BW-1:0] d;
        bit            is_rd;
        bit            is_wr;
        bit            r;
        int            beats;
        int            cycles;

        is_rd    = rd;
        is_wr    = wr && !rd;
        exp_addr = addr - (addr % AW'(LW / 8));
        beats    = 0;
        cycles   = 0;

        line_bus.line_address_i = addr;
        line_bus.line_read_i    = rd;
        line_bus.line_write_i   = wr;
        line_bus.line_wdata_i   = wl;
        mem_bus.mem_resp_i      = 1'b0;
        @(posedge clk); #1;

        while (beats < int'(NB) && cycles < 200) begin
            check("burst_rd",   LW'(mem_bus.mem_read_o),    LW'(is_rd));
            check("burst_wr",   LW'(mem_bus.mem_write_o),   LW'(is_wr));
            check("burst_addr", LW'(mem_bus.mem_address_o), LW'(exp_addr));
            check("early_resp", LW'(line_bus.line_resp_o),  LW'(0));
            if (is_wr)
                check("wbeat", LW'(mem_bus.mem_wdata_o), LW'(wl[beats*BW +: BW]));

            case (mode)
                0:       r = 1'b1;
                1:       r = (cycles % 2 == 0);
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            if (mode < 2) d = 64'h1111_1111_1111_1111 * 64'(beats + 1);
            else          d = {$urandom, $urandom};
            mem_bus.mem_resp_i  = r;
            mem_bus.mem_rdata_i = d;
            if (r && is_rd) beat_q.push_back(d);

            @(posedge clk); #1;
            if (r) beats++;
            cycles++;
        end
        mem_bus.mem_resp_i = 1'b0;

        if (beats < int'(NB)) begin
            check("beat_timeout", LW'(beats), LW'(NB));
            line_bus.line_read_i  = 1'b0;
            line_bus.line_write_i = 1'b0;
            return;
        end

        check("done_resp", LW'(line_bus.line_resp_o), LW'(1));
        check("done_rd",   LW'(mem_bus.mem_read_o),   LW'(0));
        check("done_wr",   LW'(mem_bus.mem_write_o),  LW'(0));
        if (is_rd) begin
            exp_line = '0;
            for (int i = 0; i < int'(NB); i++) exp_line[i*BW +: BW] = beat_q[i];
            model_rdata = exp_line;
            check("read_line", line_bus.line_rdata_o, model_rdata);
        end
        model_addr = exp_addr;

        line_bus.line_read_i  = 1'b0;
        line_bus.line_write_i = 1'b0;
        @(posedge clk); #1;
        idle_checks("post_done");
    endtask

    initial begin
        logic [LW-1:0] wl;
        bit            rd;
        bit            wr;

        rst                     = 1'b1;
        line_bus.line_address_i = '0;
        line_bus.line_read_i    = 1'b0;
        line_bus.line_write_i   = 1'b0;
        line_bus.line_wdata_i   = '0;
        mem_bus.mem_rdata_i     = '0;
        mem_bus.mem_resp_i      = 1'b0;
        model_rdata             = '0;
        model_addr              = '0;
        repeat (3) @(posedge clk);
        #1;
        idle_checks("reset");
        check("reset_wdata", LW'(mem_bus.mem_wdata_o), LW'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-wait read of an unaligned address.
        do_txn(1'b1, 1'b0, 32'h0000_1234, '0, 0);

        // Write with alternating memory acceptance.
        wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        do_txn(1'b0, 1'b1, 32'h0000_2000, wl, 1);

        // Read wins when both requests are raised together.
        do_txn(1'b1, 1'b1, 32'h0000_0040, {8{$urandom}}, 2);

        // Reset after two beats of a read aborts without completion.
        line_bus.line_address_i = 32'h0000_0300;
        line_bus.line_read_i    = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            check("abort_rd", LW'(mem_bus.mem_read_o), LW'(1));
            mem_bus.mem_resp_i  = 1'b1;
            mem_bus.mem_rdata_i = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        mem_bus.mem_resp_i = 1'b0;
        rst                = 1'b1;
        @(posedge clk); #1;
        model_rdata = '0;
        model_addr  = '0;
        idle_checks("abort");
        rst                  = 1'b0;
        line_bus.line_read_i = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            idle_checks("abort_idle");
        end
        do_txn(1'b1, 1'b0, 32'h0000_0080, '0, 0);

        // Back-to-back read then write.
        do_txn(1'b1, 1'b0, 32'h0000_5678, '0, 2);
        do_txn(1'b0, 1'b1, 32'h0000_9ABC, {8{$urandom}}, 2);

        // Stray memory responses while idle must be ignored.
        for (int i = 0; i < 5; i++) begin
            mem_bus.mem_resp_i  = 1'b1;
            mem_bus.mem_rdata_i = {$urandom, $urandom};
            @(posedge clk); #1;
            idle_checks("spurious");
        end
        mem_bus.mem_resp_i = 1'b0;

        // Random traffic.
        for (int t = 0; t < 24; t++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            do_txn(rd, wr, $urandom, {8{$urandom}}, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
